// File: rtl/flit_out_buffer_pkg.sv
// Shared flit format: flit width, header field width and flit-type encodings
// used by every stage of the router datapath.
package flit_out_buffer_pkg;

    localparam int FLIT_SIZE  = 32;
    localparam int HEADER_LEN = 2;

    localparam logic [HEADER_LEN-1:0] BODY_FLIT   = 2'b00;
    localparam logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'b01;
    localparam logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'b10;
    localparam logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b11;

    function automatic logic [HEADER_LEN-1:0] flit_type(input logic [FLIT_SIZE-1:0] flit);
        return flit[FLIT_SIZE-1 -: HEADER_LEN];
    endfunction

    // A packet is complete once its tail (or its only flit) has been seen.
    function automatic logic is_pkt_end(input logic [FLIT_SIZE-1:0] flit);
        return (flit_type(flit) == TAIL_FLIT) || (flit_type(flit) == SINGLE_FLIT);
    endfunction

endpackage

// File: rtl/flit_fifo_core.sv
// Generic DEPTH x WIDTH circular FIFO with registered occupancy count.
// Callers must not push when full or pop when empty.
module flit_fifo_core #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count alone define which entries are valid, and a reset RAM would
    // prevent mapping onto memory macros.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
            if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/flit_out_buffer.sv
// Packet-aware output FIFO behind the reductor: framing check, packet count,
// and optional store-and-forward release enabled by FLIT_OUT_BUF_SAF_EN.
module flit_out_buffer
    import flit_out_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FLIT_SIZE-1:0]       in,
    input  logic                       in_valid,
    output logic                       in_avail,
    output logic [FLIT_SIZE-1:0]       out,
    output logic                       out_valid,
    input  logic                       out_avail,
    output logic [$clog2(DEPTH+1)-1:0] pkt_cnt,
    output logic                       proto_err
);

    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} frame_state_t;

    frame_state_t          state;
    frame_state_t          state_nxt;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic                  frame_err;
    logic [CW-1:0]         count;
    logic                  unused_count;
    logic [HEADER_LEN-1:0] in_type;

    assign in_type      = flit_type(in);
    assign unused_count = ^count;

    flit_fifo_core #(.DEPTH(DEPTH), .WIDTH(FLIT_SIZE)) u_core (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in),
        .dout  (out),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Flow control comes from registered occupancy only.
    assign in_avail = ~full;
    assign push     = in_valid && in_avail;
    assign pop      = out_valid && out_avail;

`ifdef FLIT_OUT_BUF_SAF_EN
    // Set when a full buffer holds no complete packet and is forced into
    // cut-through; held until that oversize packet's tail leaves.
    logic draining;

    always_ff @(posedge clk) begin
        if (rst)                                draining <= 1'b0;
        else if (pop && is_pkt_end(out))        draining <= 1'b0;
        else if (full && (pkt_cnt == '0))       draining <= 1'b1;
    end

    assign out_valid = ~empty && ((pkt_cnt != '0) || full || draining);
`else
    assign out_valid = ~empty;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else begin
            case ({push && is_pkt_end(in), pop && is_pkt_end(out)})
                2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
                2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        if (push) begin
            case (state)
                IDLE:    if (in_type == HEAD_FLIT) state_nxt = IN_PKT;
                IN_PKT:  if ((in_type == TAIL_FLIT) || (in_type == SINGLE_FLIT)) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        frame_err = 1'b0;
        if (push) begin
            case (state)
                IDLE:    frame_err = (in_type == BODY_FLIT) || (in_type == TAIL_FLIT);
                IN_PKT:  frame_err = (in_type == HEAD_FLIT) || (in_type == SINGLE_FLIT);
                default: frame_err = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)            proto_err <= 1'b0;
        else if (frame_err) proto_err <= 1'b1;
    end

endmodule

// File: tb/tb_flit_out_buffer.sv
// Randomized self-checking bench for flit_out_buffer against a queue-based
// packet model; follows FLIT_OUT_BUF_SAF_EN when the build defines it.
module tb_flit_out_buffer;
    import flit_out_buffer_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH+1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [FLIT_SIZE-1:0] in;
    logic                 in_valid;
    logic                 in_avail;
    logic [FLIT_SIZE-1:0] out;
    logic                 out_valid;
    logic                 out_avail;
    logic [CW-1:0]        pkt_cnt;
    logic                 proto_err;

    always #5 clk = ~clk;

    flit_out_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .in_valid  (in_valid),
        .in_avail  (in_avail),
        .out       (out),
        .out_valid (out_valid),
        .out_avail (out_avail),
        .pkt_cnt   (pkt_cnt),
        .proto_err (proto_err)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: buffered flits in arrival order plus framing state.
    logic [FLIT_SIZE-1:0] mq[$];
    bit m_in_pkt, m_err, m_drain;

    // Random well-formed packet generator state.
    bit g_in;
    int g_left;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ends_pkt(input logic [FLIT_SIZE-1:0] f);
        logic [HEADER_LEN-1:0] t;
        t = f[FLIT_SIZE-1 -: HEADER_LEN];
        return (t == TAIL_FLIT) || (t == SINGLE_FLIT);
    endfunction

    function automatic int m_pkts();
        int n = 0;
        foreach (mq[i]) if (ends_pkt(mq[i])) n++;
        return n;
    endfunction

    function automatic bit m_valid();
        if (mq.size() == 0) return 1'b0;
`ifdef FLIT_OUT_BUF_SAF_EN
        return (m_pkts() != 0) || (mq.size() == DEPTH) || m_drain;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [FLIT_SIZE-1:0] mk(input logic [HEADER_LEN-1:0] t);
        return {t, (FLIT_SIZE-HEADER_LEN)'($urandom)};
    endfunction

    function automatic logic [FLIT_SIZE-1:0] gen_next(input bit allow_err);
        logic [HEADER_LEN-1:0] t;
        if (allow_err && ($urandom_range(0, 15) == 0)) begin
            t = HEADER_LEN'($urandom);
        end else if (!g_in) begin
            if ($urandom_range(0, 2) == 0) begin
                t = SINGLE_FLIT;
            end else begin
                t      = HEAD_FLIT;
                g_in   = 1'b1;
                g_left = $urandom_range(0, 12);
            end
        end else if (g_left > 0) begin
            t = BODY_FLIT;
            g_left--;
        end else begin
            t    = TAIL_FLIT;
            g_in = 1'b0;
        end
        return mk(t);
    endfunction

    function automatic void model_clear();
        mq.delete();
        m_in_pkt = 1'b0;
        m_err    = 1'b0;
        m_drain  = 1'b0;
    endfunction

    function automatic void model_update(input bit pushed, input bit popped, input logic [FLIT_SIZE-1:0] f);
        logic [HEADER_LEN-1:0] t;
        logic [FLIT_SIZE-1:0]  gone;
        bit                    stuck;
        stuck = (mq.size() == DEPTH) && (m_pkts() == 0);
        gone  = '0;
        if (popped) gone = mq.pop_front();
        if (popped && ends_pkt(gone)) m_drain = 1'b0;
        else if (stuck)               m_drain = 1'b1;
        if (pushed) begin
            t = f[FLIT_SIZE-1 -: HEADER_LEN];
            if (!m_in_pkt) begin
                if (t == HEAD_FLIT)        m_in_pkt = 1'b1;
                else if (t != SINGLE_FLIT) m_err    = 1'b1;
            end else if (t == TAIL_FLIT) begin
                m_in_pkt = 1'b0;
            end else if (t == HEAD_FLIT) begin
                m_err = 1'b1;
            end else if (t == SINGLE_FLIT) begin
                m_err    = 1'b1;
                m_in_pkt = 1'b0;
            end
            mq.push_back(f);
        end
    endfunction

    task automatic check_outputs();
        check("in_avail", 64'(in_avail), 64'(mq.size() != DEPTH));
        check("out_valid", 64'(out_valid), 64'(m_valid()));
        if (m_valid()) check("out", 64'(out), 64'(mq[0]));
        check("pkt_cnt", 64'(pkt_cnt), 64'(m_pkts()));
        check("proto_err", 64'(proto_err), 64'(m_err));
    endtask

    // One clock: check registered outputs, drive inputs, advance the model.
    task automatic step(input bit v, input logic [FLIT_SIZE-1:0] f, input bit oa, output bit pushed);
        bit popped;
        check_outputs();
        in_valid  = v;
        in        = f;
        out_avail = oa;
        pushed    = v && (mq.size() != DEPTH);
        popped    = m_valid() && oa;
        @(posedge clk);
        model_update(pushed, popped, f);
        #1;
    endtask

    task automatic idle(input int n, input bit oa);
        bit p;
        for (int i = 0; i < n; i++) step(1'b0, '0, oa, p);
    endtask

    task automatic send(input logic [HEADER_LEN-1:0] t, input bit oa);
        bit p;
        logic [FLIT_SIZE-1:0] f;
        f = mk(t);
        for (int i = 0; i < 50; i++) begin
            step(1'b1, f, oa, p);
            if (p) return;
        end
        check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit p;
        logic [FLIT_SIZE-1:0] cur;

        rst       = 1'b1;
        in        = '0;
        in_valid  = 1'b0;
        out_avail = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single flit straight through.
        send(SINGLE_FLIT, 1'b1);
        idle(3, 1'b1);

        // Fill to DEPTH with one packet, refused extra flit, then drain in order.
        do_reset();
        send(HEAD_FLIT, 1'b0);
        for (int i = 0; i < 6; i++) send(BODY_FLIT, 1'b0);
        send(TAIL_FLIT, 1'b0);
        step(1'b1, mk(SINGLE_FLIT), 1'b0, p);
        check("ninth_refused", 64'(p), 64'(0));
        idle(10, 1'b1);

        // Steady push+pop at occupancy 3 across the pointer wrap.
        do_reset();
        for (int i = 0; i < 3; i++) send(SINGLE_FLIT, 1'b0);
        for (int i = 0; i < 10; i++) send(SINGLE_FLIT, 1'b1);
        check("steady_occupancy", 64'(mq.size()), 64'(3));
        idle(5, 1'b1);

        // Framing errors: stray BODY, then back-to-back HEADs still forwarded.
        do_reset();
        send(BODY_FLIT, 1'b1);
        idle(3, 1'b1);
        do_reset();
        send(HEAD_FLIT, 1'b1);
        send(HEAD_FLIT, 1'b1);
        idle(4, 1'b1);

        // Reset mid-packet discards the partial packet and framing state.
        do_reset();
        send(HEAD_FLIT, 1'b0);
        send(BODY_FLIT, 1'b0);
        do_reset();
        send(SINGLE_FLIT, 1'b1);
        idle(3, 1'b1);

        // Short packet (held until tail under store-and-forward).
        do_reset();
        send(HEAD_FLIT, 1'b1);
        send(BODY_FLIT, 1'b1);
        send(BODY_FLIT, 1'b1);
        idle(2, 1'b1);
        send(TAIL_FLIT, 1'b1);
        idle(6, 1'b1);

        // Packet longer than the buffer must still get through.
        do_reset();
        send(HEAD_FLIT, 1'b1);
        for (int i = 0; i < 10; i++) send(BODY_FLIT, 1'b1);
        send(TAIL_FLIT, 1'b1);
        idle(12, 1'b1);
        check("long_pkt_drained", 64'(mq.size()), 64'(0));

        // Random well-formed traffic with random backpressure.
        do_reset();
        g_in = 1'b0;
        cur  = gen_next(1'b0);
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, cur, $urandom_range(0, 2) != 0, p);
            if (p) cur = gen_next(1'b0);
        end

        // Random traffic with framing errors and occasional resets.
        do_reset();
        g_in = 1'b0;
        cur  = gen_next(1'b1);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                g_in = 1'b0;
                cur  = gen_next(1'b1);
            end
            step($urandom_range(0, 3) != 0, cur, $urandom_range(0, 2) != 0, p);
            if (p) cur = gen_next(1'b1);
        end
        idle(40, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/flit_out_buffer.md
Name: flit_out_buffer

Overview:
- Packet-aware flit FIFO directly downstream of the N-to-1 reductor. It consumes the reductor's single flit stream (out/out_valid, backpressured through out_avail) and presents flits to the output link or next router stage.
- Decouples the reductor from link stalls. Tracks wormhole packet framing and counts complete packets held.
- Flags framing violations on the merged stream.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- FLIT_SIZE, HEADER_LEN, HEAD_FLIT, BODY_FLIT, TAIL_FLIT, SINGLE_FLIT: taken from the shared para.v include, not redeclared.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- in  input  FLIT_SIZE  flit from reductor.
- in_valid  input  1  in carries a flit.
- in_avail  output  1  buffer can accept a flit this cycle; drives the reductor's out_avail.
- out  output  FLIT_SIZE  head-of-FIFO flit.
- out_valid  output  1  out carries a flit.
- out_avail  input  1  downstream accepts this cycle.
- pkt_cnt  output  $clog2(DEPTH+1)  complete packets (tail or single flit) currently stored.
- proto_err  output  1  sticky framing-violation flag.

Behaviour:
- Flit type: in[FLIT_SIZE-1 -: HEADER_LEN], compared against the para.v encodings.
- Push occurs when in_valid && in_avail. Pop occurs when out_valid && out_avail.
- in_avail = (count != DEPTH). It depends only on registered state, with no combinational path from in_valid or out_avail.
- Storage: circular RAM with wr_ptr, rd_ptr and count (width $clog2(DEPTH+1)).
  - Pointers wrap DEPTH-1 -> 0.
  - count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- No bypass: a flit pushed in cycle t is visible at out in cycle t+1 at the earliest.
  - Throughput is 1 flit/cycle in steady state.
- out = mem[rd_ptr]. out_valid = (count != 0), subject to the optional feature below.
  - out is don't-care when out_valid is 0.
- Full: in_avail = 0. A pop that cycle frees a slot, but the slot is usable only from the next cycle.
- Empty: out_valid = 0 and no pop occurs.
- pkt_cnt:
  - +1 on push of a TAIL or SINGLE flit.
  - -1 on pop of a TAIL or SINGLE flit.
  - Both in the same cycle: unchanged.
- Framing FSM runs on pushed flits only, with states IDLE and IN_PKT.
  - IDLE: HEAD -> IN_PKT; SINGLE -> IDLE; BODY or TAIL -> set proto_err, stay IDLE.
  - IN_PKT: BODY -> IN_PKT; TAIL -> IDLE; HEAD -> set proto_err, stay IN_PKT; SINGLE -> set proto_err, go IDLE.
  - Violating flits are still stored and forwarded unchanged.
- proto_err stays set until rst.
- Reset, including mid-packet: count, wr_ptr, rd_ptr and pkt_cnt = 0; FSM = IDLE; proto_err = 0.
  - Outputs after reset: in_avail = 1, out_valid = 0.
  - Memory contents are not reset, and any partially received packet is discarded.

Optional Feature:
- Macro: FLIT_OUT_BUF_SAF_EN (store-and-forward).
- Defined:
  - out_valid = (count != 0) && ((pkt_cnt != 0) || (count == DEPTH)).
  - A packet is released only once its tail is buffered.
  - Fallback: when the buffer is full with no complete packet, the buffer switches to cut-through so packets longer than DEPTH cannot deadlock.
  - Once released this way, flits keep flowing until that packet's tail pops. This needs a one-bit "draining" register, cleared on the tail pop and on rst.
- Undefined: pure cut-through, out_valid = (count != 0). pkt_cnt is still maintained.

Decomposition:
- Flit-type encodings, HEADER_LEN and FLIT_SIZE stay in the shared para.v. A localparam for the framing FSM states is local to the block.
- One natural sub-module: flit_fifo_core, a generic DEPTH x FLIT_SIZE circular FIFO providing push, pop, full, empty and count.
- flit_out_buffer adds the framing FSM, pkt_cnt, proto_err and SAF gating.

Test Plan:
- Single push then hold out_avail = 1: push SINGLE at cycle 0 -> out_valid = 1 at cycle 1; pkt_cnt 1 at cycle 1 and 0 at cycle 2; proto_err = 0.
- Fill with out_avail = 0 (DEPTH = 8): push 8 flits as HEAD, BODY x6, TAIL -> in_avail = 0 after the 8th; a 9th in_valid is not accepted; pkt_cnt = 1. Then raise out_avail -> 8 flits emerge in order.
- Simultaneous push and pop at count = 3 for 10 cycles -> count stays 3 and order is preserved across the pointer wrap.
- Framing errors: BODY in IDLE -> proto_err = 1 next cycle and stays 1. Separately after rst: HEAD, HEAD -> proto_err = 1; both flits still output.
- Reset mid-packet: HEAD, BODY pushed, then rst for 1 cycle -> out_valid = 0, in_avail = 1, pkt_cnt = 0. A following SINGLE gives no proto_err.
- With FLIT_OUT_BUF_SAF_EN:
  - HEAD, BODY, BODY pushed -> out_valid stays 0; TAIL pushed -> out_valid = 1 the next cycle.
  - A 12-flit packet (DEPTH = 8) -> released when full, and all 12 flits are delivered.
